mem_responder: RTL and testbench

- Memory-side responder for the CPU datapath's MAR/MDR memory interface.
- Accepts Read/Write strobes, with the address taken from MAR and write data from the MDR.
- Inserts a programmable number of wait states, then returns read data on Mdatain with a one-cycle MemDone pulse.
- Sits outside the datapath, opposite the MDR input mux, and is the source of Mdatain.

---
 rtl/mem_pkg.sv | 16 +
 rtl/ram_array.sv | 26 ++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int unsigned MEM_DATA_W   = 32;
  localparam int unsigned MEM_ADDR_W   = 9;
  localparam int unsigned MEM_DEPTH    = 512;
  localparam int unsigned MEM_WAIT_MAX = 15;
  localparam int unsigned MEM_CNT_W    = 4;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, read-before-write, no reset on contents.
module ram_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: wait states, then MemDone pulse.
// Optional MEM_ERR_EN adds the MemErr port and out-of-range fault handling.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DEPTH       = MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              clr,
  input  logic [31:0]       MAR,
  input  logic [DATA_W-1:0] MDRdata,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MemDone,
  output logic              MemBusy
`ifdef MEM_ERR_EN
  ,
  output logic              MemErr
`endif
);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("mem_responder: DEPTH must equal 2**ADDR_W");
  end
  if (WAIT_CYCLES > MEM_WAIT_MAX) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES out of range");
  end

  mem_state_t            state_q, state_d;
  logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     mdata_q, mdata_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  merr_q, merr_d;

  logic                  accept, commit, req_err, ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_rdata;

`ifdef MEM_ERR_EN
  assign req_err = (MAR >= 32'(DEPTH));
  assign MemErr  = merr_q;
`else
  logic unused_hi;
  assign req_err   = 1'b0;
  assign unused_hi = ^{MAR[31:ADDR_W], merr_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    mdata_d = mdata_q;
    done_d  = 1'b0;
    merr_d  = 1'b0;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!Read && !Write) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // WAIT also absorbs the accept-to-commit edge, so the counter starts
          // at WAIT_CYCLES and a zero-wait access still spends one cycle here.
          accept  = 1'b1;
          armed_d = 1'b0;
          addr_d  = MAR[ADDR_W-1:0];
          wdata_d = MDRdata;
          wr_d    = Write;
          err_d   = req_err;
          cnt_d   = MEM_CNT_W'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          merr_d  = err_q;
          state_d = RESP;
          if (!wr_q) mdata_d = err_q ? '0 : ram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // The RAM read port follows MAR on the accept edge so read data is ready by commit.
  assign ram_addr = accept ? MAR[ADDR_W-1:0] : addr_q;
  assign ram_we   = commit && wr_q && !err_q && !clr;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      merr_q  <= merr_d;
    end
  end

  assign Mdatain = mdata_q;
  assign MemDone = done_q;
  assign MemBusy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a word-level reference model.
// A second instance with zero wait states checks the minimum latency.
module tb_mem_responder;

  localparam int unsigned WAIT_MAIN = 2;

  logic        Clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] MAR = '0;
  logic [31:0] MDRdata = '0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] Mdatain, Mdatain0;
  logic        MemDone, MemDone0;
  logic        MemBusy, MemBusy0;
`ifdef MEM_ERR_EN
  logic        MemErr, MemErr0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_mdata;

  always #5 Clk = ~Clk;

  mem_responder #(
    .WAIT_CYCLES (WAIT_MAIN)
  ) u_dut (
    .Clk     (Clk),
    .clr     (clr),
    .MAR     (MAR),
    .MDRdata (MDRdata),
    .Read    (Read),
    .Write   (Write),
    .Mdatain (Mdatain),
    .MemDone (MemDone),
    .MemBusy (MemBusy)
`ifdef MEM_ERR_EN
    ,
    .MemErr  (MemErr)
`endif
  );

  mem_responder #(
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .Clk     (Clk),
    .clr     (clr),
    .MAR     (MAR),
    .MDRdata (MDRdata),
    .Read    (Read),
    .Write   (Write),
    .Mdatain (Mdatain0),
    .MemDone (MemDone0),
    .MemBusy (MemBusy0)
`ifdef MEM_ERR_EN
    ,
    .MemErr  (MemErr0)
`endif
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_faults(input logic [31:0] mar);
`ifdef MEM_ERR_EN
    return (mar >= 32'd512);
`else
    return 1'b0;
`endif
  endfunction

  // One complete access: raise strobes, scramble MAR/MDRdata after the accept
  // edge, wait for MemDone, check against the model, then release for two edges.
  task automatic access(input logic wr, input logic rd, input logic [31:0] mar,
                        input logic [31:0] wd, input string tag);
    int n = 0;
    int n0 = 0;
    logic flt;
    int idx;
    Write = wr; Read = rd; MAR = mar; MDRdata = wd;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) begin
        MAR = $urandom;
        MDRdata = $urandom;
      end
      if (MemDone0 && n0 == 0) n0 = i;
      if (MemDone) begin
        n = i;
        break;
      end
    end
    flt = addr_faults(mar);
    idx = int'(mar[8:0]);
    if (wr) begin
      if (!flt) model_mem[idx] = wd;
    end else begin
      model_mdata = flt ? 32'h0 : model_mem[idx];
    end
    chk({tag, "_latency"}, 32'(n), 32'(WAIT_MAIN + 2));
    chk({tag, "_latency0"}, 32'(n0), 32'd2);
    chk({tag, "_mdatain"}, Mdatain, model_mdata);
    chk({tag, "_busy"}, {31'b0, MemBusy}, 32'd1);
`ifdef MEM_ERR_EN
    chk({tag, "_memerr"}, {31'b0, MemErr}, {31'b0, flt});
`endif
    Write = 1'b0; Read = 1'b0;
    step();
    chk({tag, "_done_clear"}, {30'b0, MemDone, MemBusy}, 32'd0);
    step();
  endtask

  initial begin
    int pulses;
    logic [31:0] mar;
    int unsigned a;
    int unsigned op;

    model_mdata = '0;

    // Reset with a request pending: nothing may start while clr is high
    clr = 1'b1; Read = 1'b1; MAR = 32'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_mdatain", Mdatain, 32'h0);
      chk("reset_done_busy", {30'b0, MemDone, MemBusy}, 32'd0);
      chk("reset0_done_busy", {30'b0, MemDone0, MemBusy0}, 32'd0);
    end
    Read = 1'b0; clr = 1'b0;
    step();
    chk("post_reset_idle", {30'b0, MemDone, MemBusy}, 32'd0);

    // Read latency with MAR scrambled during the wait
    access(1'b1, 1'b0, 32'd7, 32'h7777_0007, "wr7");
    access(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF, "wr5");
    access(1'b0, 1'b1, 32'd5, 32'h0, "rd5");

    // Write/readback, plus address wrap (or fault with MEM_ERR_EN)
    access(1'b1, 1'b0, 32'h10, 32'h1234_5678, "wr10");
    access(1'b0, 1'b1, 32'h10, 32'h0, "rd10");
    access(1'b0, 1'b1, 32'h210, 32'h0, "rd210");
    access(1'b0, 1'b1, 32'h200, 32'h0, "rd200");
    access(1'b0, 1'b1, 32'h5, 32'h0, "rd5b");

    // Held strobe gives one pulse; a release then re-raise gives another
    Read = 1'b1; MAR = 32'h10;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (MemDone) pulses++;
    end
    model_mdata = model_mem[16];
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_mdatain", Mdatain, model_mdata);
    Read = 1'b0;
    step();
    step();
    access(1'b0, 1'b1, 32'h5, 32'h0, "rearm");

    // Write priority when both strobes are high
    access(1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5, "both3");
    access(1'b0, 1'b1, 32'd3, 32'h0, "rd3");

    // Reset during the wait of a write aborts it
    access(1'b1, 1'b0, 32'd4, 32'h4444_4444, "wr4");
    Write = 1'b1; MAR = 32'd4; MDRdata = 32'hBAD0_BAD0;
    step();
    step();
    clr = 1'b1;
    step();
    model_mdata = '0;
    chk("midreset_done_busy", {30'b0, MemDone, MemBusy}, 32'd0);
    chk("midreset_mdatain", Mdatain, model_mdata);
    clr = 1'b0; Write = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (MemDone) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 32'd0);
    access(1'b0, 1'b1, 32'd4, 32'h0, "rd4");

    // Randomized traffic over a fully initialised window of words
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(i), $urandom, "init");
    for (int i = 0; i < 30; i++) begin
      a  = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
`ifdef MEM_ERR_EN
      mar = ($urandom_range(0, 4) == 0) ? (32'h200 | 32'(a)) : 32'(a);
`else
      mar = ($urandom & 32'hFFFF_FE00) | 32'(a);
`endif
      access(op != 0, op != 1, mar, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
